// File: rtl/config_regbank.sv
// Host-programmable config/IRQ register bank feeding the NN core control path.
// One outstanding valid/ready transaction with a registered, held response.

`timescale 1ns/1ps

module config_regbank_lane (
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  input  logic       strb,
  output logic [7:0] merged_byte,
  output logic [7:0] mask_byte
);
  assign merged_byte = strb ? new_byte : old_byte;
  assign mask_byte   = {8{strb}};
endmodule

module config_regbank #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int NUM_IRQ    = 8,
  parameter int THRESH_RST = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  input  logic [DATA_WIDTH-1:0]   hw_status,
  input  logic [NUM_IRQ-1:0]      irq_set,
  output logic                    cfg_enable,
  output logic [DATA_WIDTH-1:0]   cfg_mode,
  output logic [DATA_WIDTH-1:0]   cfg_threshold,
  output logic                    start_pulse,
  output logic                    irq_out
);
  localparam int NB       = DATA_WIDTH / 8;
  localparam int R_CTRL   = 0;
  localparam int R_MODE   = 1;
  localparam int R_THRESH = 2;
  localparam int R_STATUS = 3;
  localparam int R_IRQ_ST = 4;
  localparam int R_IRQ_EN = 5;

  localparam logic [ADDR_WIDTH:0]   NREGS    = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [DATA_WIDTH-1:0] IRQ_MASK = DATA_WIDTH'({NUM_IRQ{1'b1}});

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [DATA_WIDTH-1:0]               rd_val, wr_val, irq_clr, irq_next;
  logic [NB-1:0][7:0]                  merged, wmask;
  logic                                accept, is_err, wr_ok;

  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;
  assign is_err    = ({1'b0, req_addr} >= NREGS) ||
                     (req_write && req_addr == ADDR_WIDTH'(R_STATUS));
  assign wr_ok     = accept && req_write && !is_err;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (req_addr == ADDR_WIDTH'(i)) rd_val = regs[i];
  end

  // Byte-merge against the addressed register's current value.
  for (genvar g = 0; g < NB; g++) begin : g_lane
    config_regbank_lane u_lane (
      .old_byte    (rd_val[8*g +: 8]),
      .new_byte    (req_wdata[8*g +: 8]),
      .strb        (req_wstrb[g]),
      .merged_byte (merged[g]),
      .mask_byte   (wmask[g])
    );
  end

  always_comb begin
    wr_val = merged;
    if (req_addr == ADDR_WIDTH'(R_CTRL))        wr_val[1] = 1'b0;
    else if (req_addr == ADDR_WIDTH'(R_IRQ_EN)) wr_val = merged & IRQ_MASK;
  end

  // Set is OR'd in after the clear so a coincident set wins.
  assign irq_clr  = (wr_ok && req_addr == ADDR_WIDTH'(R_IRQ_ST)) ?
                    (req_wdata & wmask & IRQ_MASK) : '0;
  assign irq_next = (regs[R_IRQ_ST] & ~irq_clr) | DATA_WIDTH'(irq_set);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= (i == R_THRESH) ? DATA_WIDTH'(THRESH_RST) : '0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      start_pulse <= 1'b0;
      irq_out     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_ok && req_addr == ADDR_WIDTH'(i) && i != R_STATUS && i != R_IRQ_ST)
          regs[i] <= wr_val;
      regs[R_STATUS] <= hw_status;
      regs[R_IRQ_ST] <= irq_next;
      irq_out        <= |(regs[R_IRQ_ST] & regs[R_IRQ_EN]);
      start_pulse    <= wr_ok && req_addr == ADDR_WIDTH'(R_CTRL) &&
                        req_wstrb[0] && req_wdata[1];
      if (accept) begin
        resp_valid <= 1'b1;
        resp_err   <= is_err;
        resp_rdata <= (req_write || is_err) ? '0 : rd_val;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  assign cfg_enable    = regs[R_CTRL][0];
  assign cfg_mode      = regs[R_MODE];
  assign cfg_threshold = regs[R_THRESH];
endmodule

// File: tb/tb_config_regbank.sv
// Directed plus randomized checks of config_regbank against an address-map model.

`timescale 1ns/1ps

module tb_config_regbank;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata, hw_status;
  logic [7:0]  irq_set;
  logic        cfg_enable, start_pulse, irq_out;
  logic [31:0] cfg_mode, cfg_threshold;

  int total = 0;
  int bad   = 0;
  logic [31:0] m [16];

  always #5 clk = ~clk;

  config_regbank dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .hw_status(hw_status), .irq_set(irq_set),
    .cfg_enable(cfg_enable), .cfg_mode(cfg_mode), .cfg_threshold(cfg_threshold),
    .start_pulse(start_pulse), .irq_out(irq_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bytes_in(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m[i] = 32'h0;
    m[2] = 32'd10;
  endfunction

  function automatic void model_write(input logic [5:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    case (a)
      6'd0:    m[0] = bytes_in(m[0], d, s) & ~32'h2;
      6'd4:    m[4] = m[4] & ~(bytes_in(32'h0, d, s) & 32'hFF);
      6'd5:    m[5] = bytes_in(m[5], d, s) & 32'hFF;
      default: m[a[3:0]] = bytes_in(m[a[3:0]], d, s);
    endcase
  endfunction

  function automatic logic exp_irq();
    return |(m[4] & m[5]);
  endfunction

  task automatic set_status(input logic [31:0] v);
    hw_status = v;
    @(posedge clk); #1;
    m[3] = v;
  endtask

  // One transaction with resp_ready high, then one idle cycle.
  task automatic do_req(input string tag, input bit wr, input logic [5:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [7:0] irqp);
    logic [31:0] exp_rd;
    bit          exp_err, exp_start;
    int          n;
    exp_err   = (a >= 6'd16) || (wr && a == 6'd3);
    exp_rd    = (wr || exp_err) ? 32'h0 : m[a[3:0]];
    exp_start = wr && !exp_err && a == 6'd0 && s[0] && d[1];
    req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    req_valid = 1'b1; irq_set = irqp;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, "_ready_wait"}, 64'(n < 20), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; irq_set = 8'h0;
    if (wr && !exp_err) model_write(a, d, s);
    m[4] = m[4] | 32'(irqp);
    chk({tag, "_rvalid"}, 64'(resp_valid), 64'd1);
    chk({tag, "_rdata"},  64'(resp_rdata), 64'(exp_rd));
    chk({tag, "_rerr"},   64'(resp_err),   64'(exp_err));
    chk({tag, "_start"},  64'(start_pulse), 64'(exp_start));
    chk({tag, "_en"},     64'(cfg_enable), 64'(m[0][0]));
    chk({tag, "_mode"},   64'(cfg_mode),   64'(m[1]));
    chk({tag, "_thr"},    64'(cfg_threshold), 64'(m[2]));
    @(posedge clk); #1;
    chk({tag, "_rvalid_done"}, 64'(resp_valid), 64'd0);
    chk({tag, "_start_off"},   64'(start_pulse), 64'd0);
    chk({tag, "_irq"},         64'(irq_out), 64'(exp_irq()));
  endtask

  initial begin
    logic [31:0] held_d;
    logic        held_e;
    int          seen;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; resp_ready = 1'b1; hw_status = 32'h0; irq_set = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", 64'(resp_valid), 64'd0);
    chk("rst_rdata",  64'(resp_rdata), 64'd0);
    chk("rst_thr",    64'(cfg_threshold), 64'd10);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_irq",   64'(irq_out), 64'd0);
    chk("rst_start", 64'(start_pulse), 64'd0);
    set_status(32'h0);

    // Post-reset readback.
    do_req("rd_thr",   0, 6'd2, 0, 0, 0);
    do_req("rd_ctrl",  0, 6'd0, 0, 0, 0);
    do_req("rd_mode",  0, 6'd1, 0, 0, 0);
    do_req("rd_irqst", 0, 6'd4, 0, 0, 0);
    do_req("rd_irqen", 0, 6'd5, 0, 0, 0);

    // Partial-strobe write to MODE.
    do_req("wr_mode", 1, 6'd1, 32'hAABBCCDD, 4'b0101, 0);
    chk("mode_val", 64'(cfg_mode), 64'h00BB00DD);
    do_req("rd_mode2", 0, 6'd1, 0, 0, 0);
    do_req("wr_mode_nostrb", 1, 6'd1, 32'hFFFFFFFF, 4'b0000, 0);

    // Enable + start; start pulse checked for one cycle inside do_req.
    do_req("wr_ctrl", 1, 6'd0, 32'h3, 4'hF, 0);
    chk("ctrl_en", 64'(cfg_enable), 64'd1);
    do_req("rd_ctrl2", 0, 6'd0, 0, 0, 0);

    // Interrupts.
    do_req("wr_irqen", 1, 6'd5, 32'h05, 4'hF, 0);
    irq_set = 8'h01;
    @(posedge clk); #1;
    irq_set = 8'h00;
    m[4] = m[4] | 32'h1;
    chk("irq_lat0", 64'(irq_out), 64'd0);
    @(posedge clk); #1;
    chk("irq_lat1", 64'(irq_out), 64'd1);
    do_req("rd_irqst1", 0, 6'd4, 0, 0, 0);
    do_req("w1c_setwins", 1, 6'd4, 32'h01, 4'hF, 8'h01);
    do_req("rd_irqst2", 0, 6'd4, 0, 0, 0);
    do_req("w1c_clear", 1, 6'd4, 32'h01, 4'hF, 0);
    do_req("rd_irqst3", 0, 6'd4, 0, 0, 0);

    // Errors.
    set_status(32'h1234_5678);
    do_req("err_rd20", 0, 6'd20, 0, 0, 0);
    do_req("err_wr3",  1, 6'd3, 32'hDEAD_BEEF, 4'hF, 0);
    do_req("err_wr63", 1, 6'd63, 32'hFFFF_FFFF, 4'hF, 0);
    do_req("rd_status", 0, 6'd3, 0, 0, 0);

    // Response backpressure.
    resp_ready = 1'b0;
    req_write = 1'b0; req_addr = 6'd1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    held_d = resp_rdata; held_e = resp_err;
    chk("bp_rdata0", 64'(held_d), 64'(m[1]));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bp_ready",  64'(req_ready), 64'd0);
      chk("bp_rvalid", 64'(resp_valid), 64'd1);
      chk("bp_rdata",  64'(resp_rdata), 64'(held_d));
      chk("bp_rerr",   64'(resp_err), 64'(held_e));
    end
    resp_ready = 1'b1; #1;
    chk("bp_ready_release", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp_done", 64'(resp_valid), 64'd0);

    // Three back-to-back writes.
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      req_write = 1'b1; req_addr = 6'(6 + k); req_wdata = 32'h1111_0000 + 32'(k);
      req_wstrb = 4'hF; req_valid = 1'b1;
      @(posedge clk); #1;
      model_write(6'(6 + k), 32'h1111_0000 + 32'(k), 4'hF);
      if (resp_valid && req_ready) seen++;
    end
    req_valid = 1'b0;
    chk("b2b_count", 64'(seen), 64'd3);
    @(posedge clk); #1;
    chk("b2b_done", 64'(resp_valid), 64'd0);
    do_req("rd_s6", 0, 6'd6, 0, 0, 0);
    do_req("rd_s8", 0, 6'd8, 0, 0, 0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      bit          wr;
      logic [5:0]  a;
      logic [7:0]  ip;
      if ($urandom_range(0, 7) == 0) set_status($urandom);
      wr = 1'($urandom_range(0, 1));
      a  = 6'($urandom_range(0, 19));
      ip = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      do_req("rnd", wr, a, $urandom, 4'($urandom), ip);
    end

    // Reset during a pending response.
    resp_ready = 1'b0;
    req_write = 1'b0; req_addr = 6'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_rvalid", 64'(resp_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_drop",  64'(resp_valid), 64'd0);
    chk("mid_rdata", 64'(resp_rdata), 64'd0);
    chk("mid_thr",   64'(cfg_threshold), 64'd10);
    chk("mid_irq",   64'(irq_out), 64'd0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1; resp_ready = 1'b1;
    set_status(hw_status);
    do_req("post_thr",  0, 6'd2, 0, 0, 0);
    do_req("post_mode", 0, 6'd1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/config_regbank.md
Name: config_regbank

Overview:
- Parametrised successor to the accelerator's fixed four-register config block.
- Holds the CTRL/MODE/THRESHOLD/STATUS set, a W1C interrupt status/enable pair and general scratch registers.
- Host side uses a valid/ready request channel and a held response channel with error reporting.
- Sits between the AXI-lite slave adapter and the NN core control FSM, driving cfg_*, a one-cycle start pulse and a level interrupt.

Parameters:
ADDR_WIDTH, 6, word-address width; NUM_REGS must be <= 2**ADDR_WIDTH
DATA_WIDTH, 32, register width; multiple of 8
NUM_REGS, 16, implemented registers, minimum 7
NUM_IRQ, 8, interrupt sources; <= DATA_WIDTH
THRESH_RST, 10, reset value of THRESHOLD

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  block can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
req_wstrb  in  DATA_WIDTH/8  byte enables
resp_valid  out  1  response valid
resp_ready  in  1  host accepts response
resp_rdata  out  DATA_WIDTH  read data; 0 for writes/errors
resp_err  out  1  access error
hw_status  in  DATA_WIDTH  live core status, sampled into STATUS every cycle
irq_set  in  NUM_IRQ  per-source one-cycle set pulses from core
cfg_enable  out  1  CTRL[0]
cfg_mode  out  DATA_WIDTH  MODE register
cfg_threshold  out  DATA_WIDTH  THRESHOLD register
start_pulse  out  1  one-cycle start strobe
irq_out  out  1  level interrupt to host

Behaviour:
- Register map (word address):
  - 0 CTRL RW: bit0 enable; bit1 start, self-clearing, always reads 0.
  - 1 MODE RW.
  - 2 THRESHOLD RW.
  - 3 STATUS RO.
  - 4 IRQ_STATUS W1C, bits [NUM_IRQ-1:0].
  - 5 IRQ_ENABLE RW, bits [NUM_IRQ-1:0].
  - 6..NUM_REGS-1 SCRATCH RW.
- Unimplemented bits of IRQ regs read 0 and ignore writes.
- Reset (reset_n low, async):
  - All registers 0 except THRESHOLD = THRESH_RST.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - start_pulse = 0, irq_out = 0.
  - Any pending response is dropped.
- Handshake:
  - req_ready = !resp_valid || resp_ready.
  - A request is accepted when req_valid && req_ready.
  - One outstanding transaction. The response is registered: resp_valid rises the cycle after acceptance.
  - resp_rdata and resp_err are held stable until resp_valid && resp_ready.
  - Back-to-back accepts (one per cycle) when resp_ready is held high.
- Writes:
  - Each byte lane i is updated only if req_wstrb[i].
  - A write with req_wstrb = 0 completes OK with no change.
  - Write data takes effect on cfg_* outputs the cycle after acceptance.
- Reads: return the register value as it stands at the accept edge, before any same-cycle hardware update.
- Errors (resp_err = 1, resp_rdata = 0, no state change):
  - req_addr >= NUM_REGS, for read or write.
  - Write to STATUS.
- Start:
  - A write with req_wstrb[0] = 1 and wdata[1] = 1 to CTRL makes start_pulse = 1 for exactly the next cycle.
  - The enable bit updates in the same write.
- IRQ_STATUS:
  - A bit sets on irq_set.
  - A bit clears on a W1C write with 1 in that bit (respecting wstrb).
  - Set and clear of the same bit in the same cycle: set wins.
  - irq_set is ignored while reset_n is low.
- irq_out: registered, equal to OR(IRQ_STATUS & IRQ_ENABLE) from the previous cycle, so one cycle of latency after a status or enable change.
- STATUS: updates from hw_status every cycle; the read value follows the read rule above.

Test Plan:
- Reset release -> read addr 2 returns 10; addr 0, 1, 4, 5 return 0; all with resp_err = 0; irq_out = 0; start_pulse = 0.
- Write 0xAABBCCDD to addr 1 with wstrb = 4'b0101 after MODE = 0 -> read returns 0x00BB00DD; cfg_mode matches from the cycle after the write is accepted.
- Write 0x3 to CTRL -> cfg_enable = 1; start_pulse high for exactly 1 cycle; CTRL reads 0x1.
- Write IRQ_ENABLE = 0x05, pulse irq_set = 0x01 -> IRQ_STATUS reads 0x01 and irq_out rises 1 cycle later. In one cycle, W1C 0x01 together with irq_set = 0x01 -> bit stays 1. W1C 0x01 alone -> reads 0 and irq_out falls.
- Read addr 20, then write to addr 3 -> each gives resp_err = 1 and resp_rdata = 0; the subsequent STATUS read equals hw_status.
- Hold resp_ready = 0 for 3 cycles after a read -> req_ready = 0, and resp data and err stay stable. With resp_ready = 1, three back-to-back writes complete in three consecutive cycles. Assert reset_n mid-response -> resp_valid drops immediately.
